// File: rtl/wsi_unpack_pkg.sv
// Shared definitions for the WSI sample unpacker.
// Holds the WSI command codes, bus widths, the FIFO entry layout, the FSM state
// encoding and the sample formatting helper.
package wsi_unpack_pkg;

   localparam int MCMD_W  = 3;
   localparam int BLEN_W  = 12;
   localparam int IN_DW   = 32;
   localparam int OUT_DW  = 18;
   localparam int SAMP_W  = 16;
   localparam int FIFO_EW = 47;

   localparam logic [MCMD_W-1:0] MCMD_IDLE = 3'b000;
   localparam logic [MCMD_W-1:0] MCMD_WR   = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_e;

   // {MReqLast, MBurstPrecise, MBurstLength, MData, MReqInfo} = 47 bits
   typedef struct packed {
      logic              req_last;
      logic              burst_precise;
      logic [BLEN_W-1:0] burst_len;
      logic [IN_DW-1:0]  data;
      logic              req_info;
   } fifo_entry_t;

   // 16-bit sample left-justified on the 18-bit receiver path
   function automatic logic [OUT_DW-1:0] fmt_sample(input logic [SAMP_W-1:0] s);
      return {s, 2'b00};
   endfunction

endpackage

// File: rtl/wsi_sample_unpacker_if.sv
// WSI request/backpressure bundle used on both sides of the unpacker.
// Parameter DW sets the MData width (32 on the input side, 18 on the output).
// Ports (master view): MCmd, MReqLast, MBurstPrecise, MBurstLength, MData,
// MReqInfo driven by the master; SThreadBusy driven by the slave.
interface wsi_sample_unpacker_if #(
   parameter int DW = 32
);
   import wsi_unpack_pkg::*;

   logic [MCMD_W-1:0] MCmd;
   logic              MReqLast;
   logic              MBurstPrecise;
   logic [BLEN_W-1:0] MBurstLength;
   logic [DW-1:0]     MData;
   logic              MReqInfo;
   logic              SThreadBusy;

   modport master (
      output MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MReqInfo,
      input  SThreadBusy
   );

   modport slave (
      input  MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MReqInfo,
      output SThreadBusy
   );

endinterface

// File: rtl/wsi_unpack_fifo.sv
// Synchronous word FIFO for the sample unpacker.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en/wr_data  push (ignored when full, contents stay intact)
//   rd_en/rd_data  pop (rd_data is the head entry, valid when not empty)
//   count, full, empty  occupancy from the current count
//   almost_full  registered (count >= DEPTH-1); held 1 during reset so the
//                upstream stalls until the first clock after release
module wsi_unpack_fifo
   import wsi_unpack_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  fifo_entry_t wr_data,
   input  logic        rd_en,
   output fifo_entry_t rd_data,
   output logic [AW:0] count,
   output logic        full,
   output logic        almost_full,
   output logic        empty
);

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          almost_full_q, almost_full_d;
   logic          wr_ok, rd_ok;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // pointers are AW bits wide, so they wrap modulo DEPTH on their own
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      almost_full_d = (count_d >= (AW+1)'(DEPTH-1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         almost_full_q <= 1'b1;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         almost_full_q <= almost_full_d;
      end
   end

   // storage only; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data     = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign almost_full = almost_full_q;

endmodule

// File: rtl/wsi_sample_unpacker.sv
// Splits a WSI stream of 32-bit words (two 16-bit samples each) into an
// 18-bit WSI stream carrying one sample per cycle as {sample, 2'b00}, keeping
// message framing (length doubled, ReqLast on the final sample, ReqInfo copied).
// Ports:
//   dif_Clk       sole clock
//   dif_MReset_n  asynchronous active-low reset
//   in_wsi        slave side, 32-bit words in, SThreadBusy out
//   out_wsi       master side, 18-bit samples out, SThreadBusy in
// Build option: UNPACK_HI_FIRST_EN emits MData[31:16] first and attaches
// ReqLast to the MData[15:0] sample; latency is the same in both builds.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | FIFO empty, waiting for a word
// ST_LO   | presenting MData[15:0] of the head word
// ST_HI   | presenting MData[31:16] of the head word
// The half presented second is the one that pops the word.
module wsi_sample_unpacker
   import wsi_unpack_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input logic                   dif_Clk,
   input logic                   dif_MReset_n,
   wsi_sample_unpacker_if.slave  in_wsi,
   wsi_sample_unpacker_if.master out_wsi
);

`ifdef UNPACK_HI_FIRST_EN
   localparam state_e FIRST_ST = ST_HI;
   localparam state_e LAST_ST  = ST_LO;
`else
   localparam state_e FIRST_ST = ST_LO;
   localparam state_e LAST_ST  = ST_HI;
`endif

   state_e            state_q, state_d;
   fifo_entry_t       wr_entry, rd_entry;
   logic              in_wr, fifo_rd;
   logic              fifo_full, fifo_almost_full, fifo_empty;
   logic [FIFO_AW:0]  fifo_count;
   logic              more_words;
   logic [SAMP_W-1:0] cur_samp;
   logic              cur_last;

   logic [MCMD_W-1:0] out_cmd_q, out_cmd_d;
   logic              out_last_q, out_last_d;
   logic              out_precise_q, out_precise_d;
   logic [BLEN_W-1:0] out_len_q, out_len_d;
   logic [OUT_DW-1:0] out_data_q, out_data_d;
   logic              out_info_q, out_info_d;

   assign in_wr = (in_wsi.MCmd == MCMD_WR);

   always_comb begin
      wr_entry.req_last      = in_wsi.MReqLast;
      wr_entry.burst_precise = in_wsi.MBurstPrecise;
      wr_entry.burst_len     = in_wsi.MBurstLength;
      wr_entry.data          = in_wsi.MData;
      wr_entry.req_info      = in_wsi.MReqInfo;
   end

   wsi_unpack_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk         (dif_Clk),
      .rst_n       (dif_MReset_n),
      .wr_en       (in_wr),
      .wr_data     (wr_entry),
      .rd_en       (fifo_rd),
      .rd_data     (rd_entry),
      .count       (fifo_count),
      .full        (fifo_full),
      .almost_full (fifo_almost_full),
      .empty       (fifo_empty)
   );

   // A word arriving on the same edge as the pop keeps the stream gapless.
   assign more_words = (fifo_count > (FIFO_AW+1)'(1)) | (in_wr & ~fifo_full);

   always_comb begin
      state_d       = state_q;
      fifo_rd       = 1'b0;
      out_cmd_d     = MCMD_IDLE;
      out_last_d    = out_last_q;
      out_precise_d = out_precise_q;
      out_len_d     = out_len_q;
      out_data_d    = out_data_q;
      out_info_d    = out_info_q;
      cur_samp      = (state_q == ST_HI) ? rd_entry.data[IN_DW-1:SAMP_W]
                                         : rd_entry.data[SAMP_W-1:0];
      cur_last      = (state_q == LAST_ST);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = FIRST_ST;
         end
         ST_LO, ST_HI: begin
            if (!out_wsi.SThreadBusy) begin
               out_cmd_d     = MCMD_WR;
               out_data_d    = fmt_sample(cur_samp);
               out_last_d    = cur_last & rd_entry.req_last;
               out_len_d     = {rd_entry.burst_len[BLEN_W-2:0], 1'b0};
               // doubling a length >= 2048 words overflows 12 bits
               out_precise_d = rd_entry.burst_precise & ~rd_entry.burst_len[BLEN_W-1];
               out_info_d    = rd_entry.req_info;
               if (cur_last) begin
                  fifo_rd = 1'b1;
                  state_d = more_words ? FIRST_ST : ST_IDLE;
               end else begin
                  state_d = LAST_ST;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge dif_Clk or negedge dif_MReset_n) begin
      if (!dif_MReset_n) begin
         state_q       <= ST_IDLE;
         out_cmd_q     <= MCMD_IDLE;
         out_last_q    <= 1'b0;
         out_precise_q <= 1'b0;
         out_len_q     <= '0;
         out_data_q    <= '0;
         out_info_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_cmd_q     <= out_cmd_d;
         out_last_q    <= out_last_d;
         out_precise_q <= out_precise_d;
         out_len_q     <= out_len_d;
         out_data_q    <= out_data_d;
         out_info_q    <= out_info_d;
      end
   end

   assign in_wsi.SThreadBusy    = fifo_almost_full;
   assign out_wsi.MCmd          = out_cmd_q;
   assign out_wsi.MReqLast      = out_last_q;
   assign out_wsi.MBurstPrecise = out_precise_q;
   assign out_wsi.MBurstLength  = out_len_q;
   assign out_wsi.MData         = out_data_q;
   assign out_wsi.MReqInfo      = out_info_q;

endmodule

// File: tb/tb_wsi_sample_unpacker.sv
// Directed bench for wsi_sample_unpacker (default and UNPACK_HI_FIRST_EN builds).
module tb_wsi_sample_unpacker;
   import wsi_unpack_pkg::*;

   logic dif_Clk = 1'b0;
   logic dif_MReset_n = 1'b0;
   always #5 dif_Clk = ~dif_Clk;

   wsi_sample_unpacker_if #(.DW(32)) in_if ();
   wsi_sample_unpacker_if #(.DW(18)) out_if ();

   wsi_sample_unpacker dut (
      .dif_Clk      (dif_Clk),
      .dif_MReset_n (dif_MReset_n),
      .in_wsi       (in_if),
      .out_wsi      (out_if)
   );

   typedef struct packed {
      logic [17:0] data;
      logic        last;
      logic [11:0] len;
      logic        precise;
      logic        info;
      int          cyc;
   } samp_t;

   samp_t       q[$];
   int          cyc_cnt = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          busy_seen = 0;
   logic [31:0] msg_data[$];
   logic [11:0] msg_len;
   logic        msg_precise;
   logic        msg_info;

   always @(posedge dif_Clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge dif_Clk) begin
      if (out_if.MCmd === 3'b001)
         q.push_back('{data: out_if.MData, last: out_if.MReqLast, len: out_if.MBurstLength,
                       precise: out_if.MBurstPrecise, info: out_if.MReqInfo, cyc: cyc_cnt});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] exp_half(input logic [31:0] w, input bit second);
      logic [15:0] s;
`ifdef UNPACK_HI_FIRST_EN
      s = second ? w[15:0] : w[31:16];
`else
      s = second ? w[31:16] : w[15:0];
`endif
      return {s, 2'b00};
   endfunction

   task automatic drive_idle();
      in_if.MCmd          = 3'b000;
      in_if.MReqLast      = 1'b0;
      in_if.MBurstPrecise = 1'b0;
      in_if.MBurstLength  = 12'h000;
      in_if.MData         = 32'h0;
      in_if.MReqInfo      = 1'b0;
   endtask

   task automatic drive_word(input logic [31:0] d, input logic last);
      in_if.MCmd          = 3'b001;
      in_if.MReqLast      = last;
      in_if.MBurstPrecise = msg_precise;
      in_if.MBurstLength  = msg_len;
      in_if.MData         = d;
      in_if.MReqInfo      = msg_info;
   endtask

   // Upstream that honours SThreadBusy as seen just after each edge.
   task automatic send_msg();
      int i = 0;
      int k = 0;
      while (i < msg_data.size() && k < 400) begin
         @(posedge dif_Clk); #1;
         if (!in_if.SThreadBusy) begin
            drive_word(msg_data[i], i == msg_data.size() - 1);
            i++;
         end else begin
            busy_seen++;
            drive_idle();
         end
         k++;
      end
      @(posedge dif_Clk); #1;
      drive_idle();
      chk("send_done", i, msg_data.size());
   endtask

   task automatic wait_samples(input int n, input string tag);
      int k = 0;
      while (q.size() < n && k < 300) begin
         @(negedge dif_Clk);
         k++;
      end
      chk({tag, "_count"}, q.size(), n);
   endtask

   task automatic compare_msg(input string tag);
      logic [31:0] e;
      int n;
      n = 2 * msg_data.size();
      for (int j = 0; j < n; j++) begin
         e = {(j == n - 1) ? 1'b1 : 1'b0, msg_precise & ~msg_len[11],
              msg_len[10:0], 1'b0, exp_half(msg_data[j/2], j[0])};
         if (j < q.size())
            chk($sformatf("%s_s%0d", tag, j),
                {q[j].last, q[j].precise, q[j].len, q[j].data}, e);
         else
            chk($sformatf("%s_s%0d_missing", tag, j), 32'(q.size()), 32'(n));
      end
   endtask

   initial begin
      logic        hit;
      int          i;
      int          k;
      int          stall_bad;

      drive_idle();
      out_if.SThreadBusy = 1'b0;

      // reset state
      #12;
      chk("rst_cmd", out_if.MCmd, 3'b000);
      chk("rst_data", out_if.MData, 18'h0);
      chk("rst_fields", {out_if.MReqLast, out_if.MBurstPrecise, out_if.MBurstLength, out_if.MReqInfo}, 15'h0);
      chk("rst_in_busy", in_if.SThreadBusy, 1'b1);
      @(negedge dif_Clk);
      dif_MReset_n = 1'b1;
      #1 chk("rel_in_busy_hold", in_if.SThreadBusy, 1'b1);
      @(posedge dif_Clk); #1;
      chk("rel_in_busy_fall", in_if.SThreadBusy, 1'b0);

      // single word latency: accepted at edge N, samples at N+2 and N+3
      msg_len = 12'd1; msg_precise = 1'b1; msg_info = 1'b1;
      @(posedge dif_Clk); #1;
      drive_word(32'hBEEF_1234, 1'b1);
      @(posedge dif_Clk); #1;
      drive_idle();
      @(negedge dif_Clk);
      chk("lat_n0_cmd", out_if.MCmd, 3'b000);
      @(negedge dif_Clk);
      chk("lat_n1_cmd", out_if.MCmd, 3'b000);
      @(negedge dif_Clk);
      chk("lat_n2_cmd", out_if.MCmd, 3'b001);
`ifdef UNPACK_HI_FIRST_EN
      chk("lat_n2_data", out_if.MData, 18'h2FBBC);
`else
      chk("lat_n2_data", out_if.MData, 18'h048D0);
`endif
      chk("lat_n2_last", out_if.MReqLast, 1'b0);
      chk("lat_n2_len", out_if.MBurstLength, 12'd2);
      chk("lat_n2_info", {out_if.MBurstPrecise, out_if.MReqInfo}, 2'b11);
      @(negedge dif_Clk);
      chk("lat_n3_cmd", out_if.MCmd, 3'b001);
`ifdef UNPACK_HI_FIRST_EN
      chk("lat_n3_data", out_if.MData, 18'h048D0);
`else
      chk("lat_n3_data", out_if.MData, 18'h2FBBC);
`endif
      chk("lat_n3_last", out_if.MReqLast, 1'b1);
      @(negedge dif_Clk);
      chk("lat_n4_cmd", out_if.MCmd, 3'b000);

      // 8-word message, no backpressure
      q.delete();
      msg_data.delete();
      for (int w = 0; w < 8; w++)
         msg_data.push_back({16'hA000 + 16'(2*w+1), 16'hA000 + 16'(2*w)});
      msg_len = 12'd8; msg_precise = 1'b1; msg_info = 1'b0;
      busy_seen = 0;
      send_msg();
      wait_samples(16, "b2b");
      compare_msg("b2b");
      if (q.size() >= 16)
         chk("b2b_contiguous", q[15].cyc - q[0].cyc, 15);
      chk("b2b_busy_toggled", (busy_seen != 0) ? 1 : 0, 1);
      repeat (4) @(negedge dif_Clk);
      chk("b2b_no_extra", q.size(), 16);

      // receiver backpressure for 10 cycles mid-message
      q.delete();
      msg_data.delete();
      for (int w = 0; w < 6; w++)
         msg_data.push_back({16'hB000 + 16'(2*w+1), 16'hB000 + 16'(2*w)});
      msg_len = 12'd6; msg_precise = 1'b1; msg_info = 1'b1;
      fork
         send_msg();
         begin
            k = 0;
            while (q.size() < 3 && k < 100) begin
               @(negedge dif_Clk);
               k++;
            end
            @(posedge dif_Clk); #1;
            out_if.SThreadBusy = 1'b1;
            stall_bad = 0;
            repeat (10) begin
               @(posedge dif_Clk);
               @(negedge dif_Clk);
               if (out_if.MCmd !== 3'b000) stall_bad++;
            end
            chk("stall_out_idle", stall_bad, 0);
            chk("stall_in_busy", in_if.SThreadBusy, 1'b1);
            out_if.SThreadBusy = 1'b0;
         end
      join
      wait_samples(12, "stall");
      compare_msg("stall");
      repeat (4) @(negedge dif_Clk);
      chk("stall_no_dup", q.size(), 12);

      // length boundaries
      msg_data.delete();
      msg_data.push_back(32'h0000_0001);
      q.delete(); msg_len = 12'd2048; msg_precise = 1'b1; msg_info = 1'b0;
      send_msg();
      wait_samples(2, "len2048");
      if (q.size() >= 2) begin
         chk("len2048_s0", {q[0].precise, q[0].len}, {1'b0, 12'h000});
         chk("len2048_s1", {q[1].precise, q[1].len}, {1'b0, 12'h000});
      end
      q.delete(); msg_len = 12'd2047; msg_precise = 1'b1; msg_info = 1'b1;
      send_msg();
      wait_samples(2, "len2047");
      if (q.size() >= 2) begin
         chk("len2047_s0", {q[0].precise, q[0].len, q[0].info}, {1'b1, 12'hFFE, 1'b1});
         chk("len2047_s1", {q[1].precise, q[1].len, q[1].info}, {1'b1, 12'hFFE, 1'b1});
      end
      q.delete(); msg_len = 12'd5; msg_precise = 1'b0; msg_info = 1'b0;
      send_msg();
      wait_samples(2, "imprecise");
      if (q.size() >= 1)
         chk("imprecise_s0", {q[0].precise, q[0].len}, {1'b0, 12'h00A});

      // async reset with 3 words buffered while samples are flowing
      repeat (3) @(negedge dif_Clk);
      q.delete();
      msg_data.delete();
      for (int w = 0; w < 8; w++)
         msg_data.push_back({16'hC000 + 16'(2*w+1), 16'hC000 + 16'(2*w)});
      msg_len = 12'd8; msg_precise = 1'b1; msg_info = 1'b0;
      i = 0; k = 0; hit = 1'b0;
      while (!hit && k < 50) begin
         @(posedge dif_Clk); #1;
         if (in_if.SThreadBusy && out_if.MCmd === 3'b001 && i >= 3) begin
            hit = 1'b1;
         end else if (!in_if.SThreadBusy && i < 8) begin
            drive_word(msg_data[i], i == 7);
            i++;
         end else begin
            drive_idle();
         end
         k++;
      end
      drive_idle();
      chk("mrst_setup", hit, 1'b1);
      #2 dif_MReset_n = 1'b0;
      #1;
      chk("mrst_cmd_idle", out_if.MCmd, 3'b000);
      chk("mrst_in_busy", in_if.SThreadBusy, 1'b1);
      chk("mrst_data_zero", out_if.MData, 18'h0);
      repeat (3) @(negedge dif_Clk);
      q.delete();
      dif_MReset_n = 1'b1;
      repeat (6) @(negedge dif_Clk);
      chk("mrst_no_stale", q.size(), 0);
      msg_data.delete();
      msg_data.push_back(32'h5555_AAAA);
      msg_len = 12'd1; msg_precise = 1'b1; msg_info = 1'b1;
      send_msg();
      wait_samples(2, "mrst_fresh");
      compare_msg("mrst_fresh");
      if (q.size() >= 1)
`ifdef UNPACK_HI_FIRST_EN
         chk("mrst_fresh_first", q[0].data, 18'h15554);
`else
         chk("mrst_fresh_first", q[0].data, 18'h2AAA8);
`endif
      repeat (4) @(negedge dif_Clk);
      chk("mrst_fresh_total", q.size(), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
